// File: rtl/j1_io_uart.sv
// Memory-mapped 8N1 UART on the j1 I/O bus: TXDATA/STATUS/RXDATA/DIV at BASE..BASE+3.
// Reads are combinational; TX starts 1 clk after an accepted write; writes while busy are dropped.
module j1_io_uart #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] BASE      = 16'h1000,
  parameter logic [WIDTH-1:0] DIV_RESET = 16'd868
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             io_we,
  input  logic             io_re,
  input  logic [WIDTH-1:0] io_ptr,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  input  logic             uart_rx,
  output logic             uart_tx
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_t;

  localparam logic [WIDTH-1:0] A_TXDATA = BASE;
  localparam logic [WIDTH-1:0] A_STATUS = BASE + WIDTH'(1);
  localparam logic [WIDTH-1:0] A_RXDATA = BASE + WIDTH'(2);
  localparam logic [WIDTH-1:0] A_DIV    = BASE + WIDTH'(3);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] r_div;

  uart_st_t         r_tx_st;
  logic [WIDTH-1:0] r_tx_cnt;
  logic [WIDTH-1:0] r_tx_div;
  logic [7:0]       r_tx_sh;
  logic [2:0]       r_tx_idx;
  logic             r_tx_rdy;
  logic             r_tx;

  logic             r_rx_s1;
  logic             r_rx_s2;
  uart_st_t         r_rx_st;
  logic [WIDTH-1:0] r_rx_cnt;
  logic [WIDTH-1:0] r_rx_div;
  logic [7:0]       r_rx_sh;
  logic [2:0]       r_rx_idx;
  logic [7:0]       r_rx_byte;
  logic             r_rx_vld;
  logic             r_rx_ovr;

  logic             w_wr_tx;
  logic             w_wr_div;
  logic             w_pop;
  logic             w_rx;
  logic             w_rx_done;
  logic [WIDTH-1:0] w_rd_dat;

  assign w_wr_tx   = io_we && (io_ptr == A_TXDATA);
  assign w_wr_div  = io_we && (io_ptr == A_DIV);
  assign w_pop     = io_re && (io_ptr == A_RXDATA);
  assign w_rx      = r_rx_s2;
  assign w_rx_done = (r_rx_st == S_STOP) && (r_rx_cnt == '0) && w_rx;
  assign uart_tx   = r_tx;
  assign io_out    = w_rd_dat;

  always_comb begin
    w_rd_dat = '0;
    if (io_ptr == A_STATUS) begin
      w_rd_dat[0] = r_tx_rdy;
      w_rd_dat[1] = r_rx_vld;
      w_rd_dat[2] = r_rx_ovr;
    end else if (io_ptr == A_RXDATA) begin
      w_rd_dat[7:0] = r_rx_byte;
    end else if (io_ptr == A_DIV) begin
      w_rd_dat = r_div;
    end
  end

  // Divisors below 2 would make the RX mid-bit point degenerate, so clamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= DIV_RESET;
    end else if (w_wr_div) begin
      r_div <= (io_in < WIDTH'(2)) ? WIDTH'(2) : io_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_st  <= S_IDLE;
      r_tx_cnt <= '0;
      r_tx_div <= DIV_RESET;
      r_tx_sh  <= '0;
      r_tx_idx <= '0;
      r_tx_rdy <= 1'b1;
      r_tx     <= 1'b1;
    end else begin
      case (r_tx_st)
        S_IDLE: begin
          if (w_wr_tx && r_tx_rdy) begin
            r_tx_sh  <= io_in[7:0];
            r_tx_rdy <= 1'b0;
            r_tx     <= 1'b0;
            r_tx_div <= r_div;
            r_tx_cnt <= r_div - ONE;
            r_tx_st  <= S_START;
          end
        end
        S_START: begin
          if (r_tx_cnt == '0) begin
            r_tx     <= r_tx_sh[0];
            r_tx_sh  <= r_tx_sh >> 1;
            r_tx_idx <= '0;
            r_tx_cnt <= r_tx_div - ONE;
            r_tx_st  <= S_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt - ONE;
          end
        end
        S_DATA: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt <= r_tx_div - ONE;
            if (r_tx_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_tx_st <= S_STOP;
            end else begin
              r_tx     <= r_tx_sh[0];
              r_tx_sh  <= r_tx_sh >> 1;
              r_tx_idx <= r_tx_idx + 3'd1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - ONE;
          end
        end
        S_STOP: begin
          if (r_tx_cnt == '0) begin
            r_tx_rdy <= 1'b1;
            r_tx_st  <= S_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt - ONE;
          end
        end
        default: r_tx_st <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // START waits half a bit so every later sample lands mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_st  <= S_IDLE;
      r_rx_cnt <= '0;
      r_rx_div <= DIV_RESET;
      r_rx_sh  <= '0;
      r_rx_idx <= '0;
    end else begin
      case (r_rx_st)
        S_IDLE: begin
          if (!w_rx) begin
            r_rx_div <= r_div;
            r_rx_cnt <= (r_div >> 1) - ONE;
            r_rx_st  <= S_START;
          end
        end
        S_START: begin
          if (r_rx_cnt == '0) begin
            if (w_rx) begin
              r_rx_st <= S_IDLE;
            end else begin
              r_rx_idx <= '0;
              r_rx_cnt <= r_rx_div - ONE;
              r_rx_st  <= S_DATA;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - ONE;
          end
        end
        S_DATA: begin
          if (r_rx_cnt == '0) begin
            r_rx_sh  <= {w_rx, r_rx_sh[7:1]};
            r_rx_cnt <= r_rx_div - ONE;
            if (r_rx_idx == 3'd7) begin
              r_rx_st <= S_STOP;
            end else begin
              r_rx_idx <= r_rx_idx + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - ONE;
          end
        end
        S_STOP: begin
          if (r_rx_cnt == '0) begin
            r_rx_st <= S_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt - ONE;
          end
        end
        default: r_rx_st <= S_IDLE;
      endcase
    end
  end

  // A pop in the same cycle as a good stop frees the slot for the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_byte <= '0;
      r_rx_vld  <= 1'b0;
      r_rx_ovr  <= 1'b0;
    end else if (w_rx_done) begin
      if (!r_rx_vld || w_pop) begin
        r_rx_byte <= r_rx_sh;
        r_rx_vld  <= 1'b1;
        r_rx_ovr  <= 1'b0;
      end else begin
        r_rx_ovr  <= 1'b1;
      end
    end else if (w_pop) begin
      r_rx_vld <= 1'b0;
      r_rx_ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_j1_io_uart.sv
// Self-checking bench for j1_io_uart: directed register/frame cases plus a randomized
// mix of TX frames, RX frames and pops compared against a byte/flag reference model.
`timescale 1ns/1ps
module tb_j1_io_uart;

  localparam logic [15:0] BASE     = 16'h1000;
  localparam logic [15:0] A_TXDATA = BASE;
  localparam logic [15:0] A_STATUS = BASE + 16'd1;
  localparam logic [15:0] A_RXDATA = BASE + 16'd2;
  localparam logic [15:0] A_DIV    = BASE + 16'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_we;
  logic        io_re;
  logic [15:0] io_ptr;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic        uart_rx;
  logic        uart_tx;

  int n_checks = 0;
  int n_errors = 0;

  // reference model of the receive side
  logic       m_vld = 1'b0;
  logic       m_ovr = 1'b0;
  logic [7:0] m_byte = 8'h00;

  always #5 clk = ~clk;

  j1_io_uart #(
    .WIDTH(16),
    .BASE(BASE),
    .DIV_RESET(16'd868)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io_we(io_we),
    .io_re(io_re),
    .io_ptr(io_ptr),
    .io_in(io_in),
    .io_out(io_out),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    io_ptr = a;
    io_in  = d;
    io_we  = 1'b1;
    @(negedge clk);
    io_we  = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    io_ptr = a;
    io_re  = 1'b1;
    #1 d = io_out;
    @(negedge clk);
    io_re  = 1'b0;
  endtask

  function automatic logic [15:0] exp_status(input logic tx_rdy);
    return {13'd0, m_ovr, m_vld, tx_rdy};
  endfunction

  task automatic check_status(input string tag);
    logic [15:0] d;
    cpu_read(A_STATUS, d);
    chk(tag, d, exp_status(1'b1));
  endtask

  task automatic pop_and_check(input string tag);
    logic [15:0] d;
    cpu_read(A_RXDATA, d);
    chk(tag, d, {8'h00, m_byte});
    m_vld = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Sends one 8N1 frame; the model is updated only for a good stop bit.
  task automatic rx_send(input logic [7:0] b, input int div, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      uart_rx = frame[k];
      repeat (div - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * div + 6) @(negedge clk);
    if (stop) begin
      if (!m_vld) begin
        m_byte = b;
        m_vld  = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  // Checks the line bit-by-bit and tx_ready every cycle of the frame and one beyond.
  task automatic tx_frame(input logic [7:0] b, input int div, input bit mid_write);
    logic [9:0]  frame;
    logic [15:0] st;
    frame = {1'b1, b, 1'b0};
    cpu_write(A_TXDATA, {8'h00, b});
    for (int i = 0; i <= 10 * div; i++) begin
      io_ptr = A_STATUS;
      #1 st = io_out;
      chk("tx_line", {15'd0, uart_tx}, (i < 10 * div) ? {15'd0, frame[i / div]} : 16'd1);
      chk("tx_ready", {15'd0, st[0]}, (i < 10 * div) ? 16'd0 : 16'd1);
      if (mid_write && i == 3 * div) begin
        io_ptr = A_TXDATA;
        io_in  = {8'h00, ~b};
        io_we  = 1'b1;
      end
      @(negedge clk);
      io_we = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  b;
    int          div;
    logic        stop;

    rst_n = 1'b0; io_we = 1'b0; io_re = 1'b0;
    io_ptr = '0;  io_in = '0;   uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // register reset values
    cpu_read(A_STATUS, d); chk("rst_status", d, 16'h0001);
    cpu_read(A_DIV, d);    chk("rst_div", d, 16'h0364);
    cpu_read(A_RXDATA, d); chk("rst_rxdata", d, 16'h0000);
    cpu_read(A_TXDATA, d); chk("rst_txdata", d, 16'h0000);
    cpu_read(BASE + 16'd4, d); chk("unmapped", d, 16'h0000);
    chk("rst_tx", {15'd0, uart_tx}, 16'd1);

    // TX 0xA5 at 4 clk/bit with a dropped write mid-frame
    cpu_write(A_DIV, 16'd4);
    cpu_read(A_DIV, d); chk("div4", d, 16'd4);
    tx_frame(8'hA5, 4, 1'b1);
    repeat (8) @(negedge clk);
    chk("tx_idle_after", {15'd0, uart_tx}, 16'd1);

    // RX single frame and pop
    rx_send(8'h3C, 4, 1'b1);
    cpu_read(A_STATUS, d); chk("rx_status", d, 16'h0003);
    pop_and_check("rx_3c");
    cpu_read(A_STATUS, d); chk("rx_status_pop", d, 16'h0001);

    // overrun keeps the first byte
    rx_send(8'h11, 4, 1'b1);
    rx_send(8'h22, 4, 1'b1);
    cpu_read(A_STATUS, d); chk("ovr_status", d, 16'h0007);
    pop_and_check("ovr_first");
    cpu_read(A_STATUS, d); chk("ovr_status_pop", d, 16'h0001);

    // one-clock glitch and framing error both leave rx_valid clear
    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk); uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    cpu_read(A_STATUS, d); chk("glitch_status", d, 16'h0001);
    rx_send(8'h5A, 4, 1'b0);
    cpu_read(A_STATUS, d); chk("frame_err_status", d, 16'h0001);

    // async reset in data bit 3 of a 0x00 frame, then of a 0xFF frame
    cpu_write(A_DIV, 16'd4);
    cpu_write(A_TXDATA, 16'h0000);
    repeat (17) @(negedge clk);
    chk("pre_rst_tx", {15'd0, uart_tx}, 16'd0);
    rst_n = 1'b0;
    #1 chk("rst_tx_async", {15'd0, uart_tx}, 16'd1);
    io_ptr = A_DIV;
    #1 chk("rst_div_async", io_out, 16'h0364);
    @(negedge clk); rst_n = 1'b1;
    cpu_read(A_STATUS, d); chk("post_rst_status", d, 16'h0001);
    cpu_write(A_DIV, 16'd4);
    cpu_write(A_TXDATA, 16'h00FF);
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_tx_ff", {15'd0, uart_tx}, 16'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("tx_after_rst", {15'd0, uart_tx}, 16'd1);
    cpu_read(A_STATUS, d); chk("post_rst_status2", d, 16'h0001);

    // partial RX frame discarded by reset
    cpu_write(A_DIV, 16'd4);
    @(negedge clk); uart_rx = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    cpu_read(A_STATUS, d); chk("rx_rst_status", d, 16'h0001);

    // divisor clamp
    cpu_write(A_DIV, 16'd0); cpu_read(A_DIV, d); chk("div_clamp0", d, 16'd2);
    cpu_write(A_DIV, 16'd1); cpu_read(A_DIV, d); chk("div_clamp1", d, 16'd2);

    // randomized mix
    m_vld = 1'b0; m_ovr = 1'b0; m_byte = 8'h00;
    for (int it = 0; it < 14; it++) begin
      div = $urandom_range(2, 7);
      b   = 8'($urandom);
      cpu_write(A_DIV, 16'(div));
      cpu_read(A_DIV, d); chk("rnd_div", d, 16'(div));
      case ($urandom_range(0, 2))
        0: tx_frame(b, div, ($urandom_range(0, 1) == 1));
        1: begin
          stop = ($urandom_range(0, 3) != 0);
          rx_send(b, div, stop);
          check_status("rnd_rx_status");
        end
        default: begin
          pop_and_check("rnd_pop");
          check_status("rnd_pop_status");
        end
      endcase
    end
    pop_and_check("final_pop");
    check_status("final_status");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
